// File: rtl/rotary_enc_ctrl_pkg.sv
// Shared constants for the panel rotary encoder front end and its consumers.
package rotary_enc_ctrl_pkg;

    localparam logic [2:0] ENC_STATE_FM   = 3'b110;
    localparam logic [2:0] ENC_STATE_AM   = 3'b101;
    localparam logic [2:0] ENC_STATE_WAVE = 3'b011;

    typedef enum logic [2:0] {
        ST_FM   = ENC_STATE_FM,
        ST_AM   = ENC_STATE_AM,
        ST_WAVE = ENC_STATE_WAVE
    } enc_st_e;

    // Filter counter width; a filter length of 1 still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned filt);
        return (filt > 1) ? $clog2(filt) : 1;
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// 2-FF synchroniser plus stable-time filter for one raw asynchronous input.
module enc_debounce
    import rotary_enc_ctrl_pkg::*;
#(
    parameter int unsigned FILT = 1200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt,
    output logic prev
);

    localparam int unsigned CW = cnt_width(FILT);

    logic [1:0]    sync_q;
    logic [1:0]    settle_q;
    logic          filt_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;

    // Until the synchroniser has flushed after reset, the filtered level
    // adopts the first real sample silently so a level held through reset
    // never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            settle_q <= 2'b00;
            filt_q   <= 1'b1;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            settle_q <= {settle_q[0], 1'b1};
            prev_q   <= filt_q;
            if (!settle_q[1]) begin
                cnt_q <= '0;
                if (settle_q[0]) begin
                    filt_q <= sync_q[0];
                    prev_q <= sync_q[0];
                end
            end else if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign filt = filt_q;
    assign prev = prev_q;

endmodule

// File: rtl/rotary_enc_ctrl.sv
// Rotary encoder front end: detent step pulses and push-switch parameter select.
module rotary_enc_ctrl
    import rotary_enc_ctrl_pkg::*;
#(
    parameter int unsigned ENC_FILT = 1200,
    parameter int unsigned SW_FILT  = 240000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_sw,
    output logic       enc_pulse_l,
    output logic       enc_pulse_r,
    output logic [2:0] enc_st
);

    logic a_filt, a_prev;
    logic b_filt, b_prev_unused;
    logic sw_filt, sw_prev;
    logic a_fall_c, sw_fall_c;
    logic pulse_l_q, pulse_r_q;
    enc_st_e state_q, state_d;

    enc_debounce #(.FILT(ENC_FILT)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_a),
        .filt  (a_filt),
        .prev  (a_prev)
    );

    enc_debounce #(.FILT(ENC_FILT)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_b),
        .filt  (b_filt),
        .prev  (b_prev_unused)
    );

    enc_debounce #(.FILT(SW_FILT)) u_deb_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_sw),
        .filt  (sw_filt),
        .prev  (sw_prev)
    );

    // Only the falling edge of A marks a detent; B gives the direction.
    assign a_fall_c  = a_prev & ~a_filt;
    assign sw_fall_c = sw_prev & ~sw_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_l_q <= 1'b0;
            pulse_r_q <= 1'b0;
        end else begin
            pulse_l_q <= a_fall_c & ~b_filt;
            pulse_r_q <= a_fall_c & b_filt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FM;
        end else begin
            state_q <= state_d;
        end
    end

    // Any corrupted state value falls back to FM on the next press.
    always_comb begin
        state_d = state_q;
        if (sw_fall_c) begin
            case (state_q)
                ST_FM:   state_d = ST_AM;
                ST_AM:   state_d = ST_WAVE;
                ST_WAVE: state_d = ST_FM;
                default: state_d = ST_FM;
            endcase
        end
    end

    assign enc_pulse_l = pulse_l_q;
    assign enc_pulse_r = pulse_r_q;
    assign enc_st      = state_q;

endmodule
